// File: rtl/grs_shift_pkg.sv
// Shared types and helpers for the GRS multi-step shifter.
// Covers FSM state encoding, direction codes, the GRS bundle and count clamping.
package grs_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } grs_t;

  // Beyond width+3 right shifts every data bit has already reached sticky.
  function automatic int unsigned clamp_count(input int unsigned cnt, input int unsigned width);
    return (cnt > width + 3) ? width + 3 : cnt;
  endfunction

endpackage

// File: rtl/grs_step_unit.sv
// One combinational shift step of up to k bits over {result, guard, round}.
// Sticky absorbs every bit that falls below the round position on right shifts.
module grs_step_unit
  import grs_shift_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = 8
) (
  input  logic [WIDTH-1:0] cur_result,
  input  grs_t             cur_grs,
  input  logic [CNT_W-1:0] k,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt_result,
  output grs_t             nxt_grs
);

  localparam int EXT_W = WIDTH + 2;

  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] ext_sh;
  logic [EXT_W-1:0] lost_mask;

  assign ext       = {cur_result, cur_grs.guard, cur_grs.round};
  assign lost_mask = ~({EXT_W{1'b1}} << k);

  always_comb begin
    ext_sh  = ext;
    nxt_grs = cur_grs;
    if (dir == DIR_LEFT) begin
      ext_sh = ext << k;
    end else begin
      ext_sh         = ext >> k;
      nxt_grs.sticky = cur_grs.sticky | (|(ext & lost_mask));
    end
    nxt_result    = ext_sh[EXT_W-1:2];
    nxt_grs.guard = ext_sh[1];
    nxt_grs.round = ext_sh[0];
  end

endmodule

// File: rtl/grs_multistep_shifter.sv
// Counted mantissa shifter moving up to STEP bits per clock with guard/round/sticky.
// Count is clamped on load; Done pulses for one cycle after the final shift.
module grs_multistep_shifter
  import grs_shift_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = 8,
  parameter int STEP  = 1
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data,
  input  logic [CNT_W-1:0] Count,
  input  logic             Direction,
  input  logic             Guard_in,
  input  logic             Round_in,
  input  logic             Sticky_in,
  output logic [WIDTH-1:0] Result,
  output logic             guard,
  output logic             round,
  output logic             sticky,
  output logic             shift_enable,
  output logic             Done
);

  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] result_q;
  grs_t             grs_q;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_load;
  logic [CNT_W-1:0] rem_nxt;
  logic [CNT_W-1:0] k;
  logic             dir_q;
  logic [WIDTH-1:0] step_result;
  grs_t             step_grs;

  assign rem_load = CNT_W'(clamp_count(32'(Count), WIDTH));
  assign k        = (rem < STEP_C) ? rem : STEP_C;
  assign rem_nxt  = rem - k;

  grs_step_unit #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_step (
    .cur_result(result_q),
    .cur_grs   (grs_q),
    .k         (k),
    .dir       (dir_q),
    .nxt_result(step_result),
    .nxt_grs   (step_grs)
  );

  always_ff @(posedge Clk) begin
    if (Clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Load) state_nxt = (rem_load == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_enable = (state == SHIFT);
    Done         = (state == DONE);
  end

  // Operands are captured at load so later input changes cannot disturb the shift.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      result_q <= '0;
      grs_q    <= '0;
      rem      <= '0;
      dir_q    <= DIR_RIGHT;
    end else begin
      case (state)
        IDLE: if (Load) begin
          result_q <= Data;
          grs_q    <= {Guard_in, Round_in, Sticky_in};
          dir_q    <= Direction;
          rem      <= rem_load;
        end
        SHIFT: begin
          result_q <= step_result;
          grs_q    <= step_grs;
          rem      <= rem_nxt;
        end
        default: ;
      endcase
    end
  end

  assign Result = result_q;
  assign guard  = grs_q.guard;
  assign round  = grs_q.round;
  assign sticky = grs_q.sticky;

endmodule

// File: tb/tb_grs_multistep_shifter.sv
// Scoreboard bench for grs_multistep_shifter at STEP = 1, 4 and 8 in parallel.
// A bit-serial reference model predicts results; cycle counts give shift/latency expectations.
module tb_grs_multistep_shifter;

  localparam int W  = 24;
  localparam int CW = 8;
  localparam int NI = 3;
  localparam int CL = W + 3;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Clear, Load, Direction, gi, ri, si;
  logic [W-1:0]  Data;
  logic [CW-1:0] Count;

  logic [NI-1:0][W-1:0] res;
  logic [NI-1:0]        g, r, s, se, dn;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
  endfunction

  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int S = (i == 0) ? 1 : ((i == 1) ? 4 : 8);
    grs_multistep_shifter #(.WIDTH(W), .CNT_W(CW), .STEP(S)) u_dut (
      .Clk         (Clk),
      .Clear       (Clear),
      .Load        (Load),
      .Data        (Data),
      .Count       (Count),
      .Direction   (Direction),
      .Guard_in    (gi),
      .Round_in    (ri),
      .Sticky_in   (si),
      .Result      (res[i]),
      .guard       (g[i]),
      .round       (r[i]),
      .sticky      (s[i]),
      .shift_enable(se[i]),
      .Done        (dn[i])
    );
  end

  typedef struct {
    logic [W-1:0] res;
    logic         g, r, s;
    int           n;
  } exp_t;

  exp_t sb_q[$];

  // Reference: n single-bit shifts, one at a time.
  function automatic exp_t model(input logic [W-1:0] d, input int n, input logic dir,
                                 input logic g0, input logic r0, input logic s0);
    exp_t e;
    e.res = d; e.g = g0; e.r = r0; e.s = s0; e.n = n;
    for (int j = 0; j < n; j++) begin
      if (!dir) begin
        e.s   = e.s | e.r;
        e.r   = e.g;
        e.g   = e.res[0];
        e.res = e.res >> 1;
      end else begin
        e.res = {e.res[W-2:0], e.g};
        e.g   = e.r;
        e.r   = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] d, input int c, input logic dir,
                        input logic g0, input logic r0, input logic s0);
    int           cl;
    int           sh[NI], lat[NI], dcnt[NI];
    logic [W-1:0] cres[NI];
    logic [2:0]   cgrs[NI];
    exp_t         e;
    int           stp, exp_sh;
    cl = (c > CL) ? CL : c;
    sb_q.push_back(model(d, cl, dir, g0, r0, s0));
    @(posedge Clk); #1;
    Load = 1'b1; Data = d; Count = CW'(c); Direction = dir; gi = g0; ri = r0; si = s0;
    @(posedge Clk); #1;
    Load = 1'b0; Data = W'($urandom); Count = CW'($urandom); Direction = ~dir;
    gi = ~g0; ri = ~r0; si = ~s0;
    for (int i = 0; i < NI; i++) begin
      sh[i] = 0; lat[i] = 0; dcnt[i] = 0; cres[i] = '0; cgrs[i] = '0;
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge Clk);
      for (int i = 0; i < NI; i++) begin
        if (se[i]) sh[i]++;
        if (dn[i]) begin
          dcnt[i]++;
          if (lat[i] == 0) begin
            lat[i]  = cyc;
            cres[i] = res[i];
            cgrs[i] = {g[i], r[i], s[i]};
          end
        end
      end
    end
    e = sb_q.pop_front();
    for (int i = 0; i < NI; i++) begin
      stp    = step_of(i);
      exp_sh = (e.n + stp - 1) / stp;
      check($sformatf("s%0d_c%0d_result", stp, c), cres[i], e.res);
      check($sformatf("s%0d_c%0d_grs", stp, c), cgrs[i], {e.g, e.r, e.s});
      check($sformatf("s%0d_c%0d_shift_cycles", stp, c), sh[i], exp_sh);
      check($sformatf("s%0d_c%0d_done_latency", stp, c), lat[i], exp_sh + 1);
      check($sformatf("s%0d_c%0d_done_pulses", stp, c), dcnt[i], 1);
      check($sformatf("s%0d_c%0d_hold", stp, c), {res[i], g[i], r[i], s[i]},
            {e.res, e.g, e.r, e.s});
    end
  endtask

  initial begin
    exp_t e2;
    int   dsum, ssum;
    Clear = 1'b1; Load = 1'b1; Data = 24'hFFFFFF; Count = 8'd3; Direction = 1'b0;
    gi = 1'b1; ri = 1'b1; si = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("s%0d_reset_result", step_of(i)), res[i], 0);
      check($sformatf("s%0d_reset_grs_se_done", step_of(i)), {g[i], r[i], s[i], se[i], dn[i]}, 0);
    end
    @(posedge Clk); #1;
    Clear = 1'b0; Load = 1'b0;

    run_op(24'h0F0FFE, 6,   1'b0, 1'b0, 1'b0, 1'b0);
    run_op(24'hA15FC2, 4,   1'b1, 1'b1, 1'b0, 1'b1);
    run_op(24'hFF00FE, 0,   1'b0, 1'b1, 1'b0, 1'b1);
    run_op(24'h5ABCDE, 30,  1'b0, 1'b0, 1'b0, 1'b0);
    run_op(24'h800001, 255, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op(24'hC00003, 27,  1'b1, 1'b1, 1'b1, 1'b1);
    run_op(24'h123456, 26,  1'b0, 1'b0, 1'b1, 1'b0);

    // Busy Load ignored, then Clear (with a simultaneous Load) abandons the shift.
    e2 = model(24'h5ABCDE, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    Load = 1'b1; Data = 24'h5ABCDE; Count = 8'd20; Direction = 1'b0; gi = 0; ri = 0; si = 0;
    @(posedge Clk); #1;
    Load = 1'b0;
    @(posedge Clk); #1;
    Load = 1'b1; Data = 24'h00FFFF; Count = 8'd5; Direction = 1'b1;
    @(posedge Clk); #1;
    Clear = 1'b1; Load = 1'b1; Data = 24'hFFFFFF; Count = 8'd3;
    @(negedge Clk);
    check("s1_busy_load_ignored", {res[0], g[0], r[0], s[0]}, {e2.res, e2.g, e2.r, e2.s});
    check("busy_still_shifting", se, {NI{1'b1}});
    @(posedge Clk); #1;
    Clear = 1'b0; Load = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < NI; i++)
      check($sformatf("s%0d_clear_outputs", step_of(i)),
            {res[i], g[i], r[i], s[i], se[i], dn[i]}, 0);
    dsum = 0; ssum = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge Clk);
      for (int i = 0; i < NI; i++) begin
        if (dn[i]) dsum++;
        if (se[i]) ssum++;
      end
    end
    check("clear_no_done", dsum, 0);
    check("clear_idle", ssum, 0);

    for (int t = 0; t < 6; t++)
      run_op(W'($urandom), $urandom_range(0, 40), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
